// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo; hwm/hwm_clr exist only under SYNC_FIFO_HWM_EN.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  flush;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] di;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  o_valid;
    logic                  isEmpty;
    logic                  isFull;
    logic                  isAlmostEmpty;
    logic                  isAlmostFull;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  overflow;
    logic                  underflow;
`ifdef SYNC_FIFO_HWM_EN
    logic [ADDR_WIDTH:0]   hwm;
    logic                  hwm_clr;
`endif

    modport master (
        output flush, write_en, di, read_en,
`ifdef SYNC_FIFO_HWM_EN
        output hwm_clr,
        input  hwm,
`endif
        input  d_out, o_valid, isEmpty, isFull, isAlmostEmpty, isAlmostFull,
        input  fill_count, overflow, underflow
    );

    modport slave (
        input  flush, write_en, di, read_en,
`ifdef SYNC_FIFO_HWM_EN
        input  hwm_clr,
        output hwm,
`endif
        output d_out, o_valid, isEmpty, isFull, isAlmostEmpty, isAlmostFull,
        output fill_count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, full 2^ADDR_WIDTH depth, registered read data, sticky error flags.
// Optional high-water mark tracking when SYNC_FIFO_HWM_EN is defined.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input logic       sys_clock,
    input logic       reset,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] FULL_L = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_L   = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_L   = PTR_W'(AE_THRESH);

    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
        $error("sync_fifo: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, count, count_next;
    logic [DATA_WIDTH-1:0] d_out_r;
    logic                  o_valid_r, overflow_r, underflow_r;
    logic                  is_full, is_empty, wr_acc, rd_acc;

    assign is_full  = (count == FULL_L);
    assign is_empty = (count == '0);
    assign wr_acc   = bus.write_en & ~is_full;
    assign rd_acc   = bus.read_en & ~is_empty;

    always_comb begin
        count_next = count;
        if (bus.flush) begin
            count_next = '0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count_next = count + ONE;
                2'b01:   count_next = count - ONE;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            d_out_r     <= '0;
            o_valid_r   <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.flush) begin
            // d_out and the sticky error flags deliberately survive a flush
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_valid_r <= 1'b0;
        end else begin
            count     <= count_next;
            o_valid_r <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + ONE;
                d_out_r <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            if (bus.write_en & is_full)  overflow_r  <= 1'b1;
            if (bus.read_en  & is_empty) underflow_r <= 1'b1;
        end
    end

    // Storage is not reset; contents are only meaningful once written
    always_ff @(posedge sys_clock) begin
        if (!reset && !bus.flush && wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.di;
        end
    end

`ifdef SYNC_FIFO_HWM_EN
    logic [PTR_W-1:0] hwm_r;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            hwm_r <= '0;
        end else if (bus.hwm_clr) begin
            hwm_r <= count;
        end else if (count_next > hwm_r) begin
            hwm_r <= count_next;
        end
    end

    assign bus.hwm = hwm_r;
`endif

    assign bus.d_out         = d_out_r;
    assign bus.o_valid       = o_valid_r;
    assign bus.isEmpty       = is_empty;
    assign bus.isFull        = is_full;
    assign bus.isAlmostEmpty = (count <= AE_L);
    assign bus.isAlmostFull  = (count >= AF_L);
    assign bus.fill_count    = count;
    assign bus.overflow      = overflow_r;
    assign bus.underflow     = underflow_r;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: fill/drain, over/underflow, wraparound, full+both, flush.
module tb_sync_fifo;
    logic sys_clock = 1'b0;
    logic reset     = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 sys_clock = ~sys_clock;

    sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sync_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .sys_clock(sys_clock),
        .reset    (reset),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic idle();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.di = '0;
`ifdef SYNC_FIFO_HWM_EN
        bus.hwm_clr = 1'b0;
`endif
        do_reset();
        check("rst_fill", 32'(bus.fill_count), 0);
        check("rst_empty", 32'(bus.isEmpty), 1);
        check("rst_full", 32'(bus.isFull), 0);
        check("rst_ae", 32'(bus.isAlmostEmpty), 1);
        check("rst_af", 32'(bus.isAlmostFull), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_udf", 32'(bus.underflow), 0);
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_dout", 32'(bus.d_out), 0);

        // fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            bus.write_en = 1'b1;
            bus.di = 8'(i);
            tick();
            check("fill_cnt", 32'(bus.fill_count), 32'(i));
            check("fill_af", 32'(bus.isAlmostFull), (i >= 14) ? 1 : 0);
            check("fill_ae", 32'(bus.isAlmostEmpty), (i <= 2) ? 1 : 0);
        end
        check("full_flag", 32'(bus.isFull), 1);
        check("full_ovf", 32'(bus.overflow), 0);
`ifdef SYNC_FIFO_HWM_EN
        check("hwm_full", 32'(bus.hwm), 16);
`endif

        // write into full FIFO
        bus.di = 8'hAA;
        tick();
        check("ovf_set", 32'(bus.overflow), 1);
        check("ovf_cnt", 32'(bus.fill_count), 16);
        bus.write_en = 1'b0;
        tick();
        check("ovf_sticky", 32'(bus.overflow), 1);

        // drain in order
        for (int i = 1; i <= 16; i++) begin
            bus.read_en = 1'b1;
            tick();
            check("drain_valid", 32'(bus.o_valid), 1);
            check("drain_data", 32'(bus.d_out), 32'(i));
        end
        bus.read_en = 1'b0;
        check("drain_empty", 32'(bus.isEmpty), 1);
        tick();
        check("idle_valid", 32'(bus.o_valid), 0);
        check("idle_hold", 32'(bus.d_out), 32'h10);

        // read from empty
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        check("udf_set", 32'(bus.underflow), 1);
        check("udf_valid", 32'(bus.o_valid), 0);
        check("udf_hold", 32'(bus.d_out), 32'h10);
        check("udf_cnt", 32'(bus.fill_count), 0);

        // half full, then 20 simultaneous read/write cycles across the wrap
        for (int i = 0; i < 8; i++) begin
            bus.write_en = 1'b1;
            bus.di = 8'(8'h30 + i);
            tick();
        end
        check("half_cnt", 32'(bus.fill_count), 8);
        for (int i = 0; i < 20; i++) begin
            bus.write_en = 1'b1;
            bus.read_en  = 1'b1;
            bus.di = 8'(8'h38 + i);
            tick();
            check("rw_cnt", 32'(bus.fill_count), 8);
            check("rw_data", 32'(bus.d_out), 32'(8'h30 + i));
            check("rw_valid", 32'(bus.o_valid), 1);
        end
        bus.write_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.read_en = 1'b1;
            tick();
            check("rw_tail", 32'(bus.d_out), 32'(8'h44 + i));
        end
        bus.read_en = 1'b0;
        check("rw_empty", 32'(bus.isEmpty), 1);

        // full FIFO with write and read together
        do_reset();
        check("rst2_ovf", 32'(bus.overflow), 0);
        for (int i = 0; i < 16; i++) begin
            bus.write_en = 1'b1;
            bus.di = 8'(8'h60 + i);
            tick();
        end
        check("full2", 32'(bus.isFull), 1);
        bus.read_en = 1'b1;
        bus.di = 8'hEE;
        tick();
        check("fb_data", 32'(bus.d_out), 32'h60);
        check("fb_valid", 32'(bus.o_valid), 1);
        check("fb_cnt", 32'(bus.fill_count), 15);
        check("fb_ovf", 32'(bus.overflow), 1);
        bus.write_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("fb_drain", 32'(bus.d_out), 32'(8'h60 + i));
        end
        bus.read_en = 1'b0;
        check("fb_empty", 32'(bus.isEmpty), 1);
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        check("fb_udf", 32'(bus.underflow), 1);

        // count 5, then flush with a concurrent write
        for (int i = 0; i < 5; i++) begin
            bus.write_en = 1'b1;
            bus.di = 8'(8'h70 + i);
            tick();
        end
        check("fl_pre", 32'(bus.fill_count), 5);
        bus.flush = 1'b1;
        bus.di = 8'h77;
        tick();
        bus.flush = 1'b0;
        bus.write_en = 1'b0;
        check("fl_cnt", 32'(bus.fill_count), 0);
        check("fl_empty", 32'(bus.isEmpty), 1);
        check("fl_ovf", 32'(bus.overflow), 1);
        check("fl_udf", 32'(bus.underflow), 1);
        check("fl_valid", 32'(bus.o_valid), 0);
        check("fl_hold", 32'(bus.d_out), 32'h6F);
`ifdef SYNC_FIFO_HWM_EN
        check("hwm_flush", 32'(bus.hwm), 16);
`endif
        bus.write_en = 1'b1;
        bus.di = 8'h5A;
        tick();
        bus.write_en = 1'b0;
        check("fl_wr_cnt", 32'(bus.fill_count), 1);
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        check("fl_rd_data", 32'(bus.d_out), 32'h5A);
        check("fl_rd_valid", 32'(bus.o_valid), 1);
`ifdef SYNC_FIFO_HWM_EN
        bus.hwm_clr = 1'b1;
        tick();
        bus.hwm_clr = 1'b0;
        check("hwm_clr", 32'(bus.hwm), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
